// File: rtl/lsu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_mem_arbiter
//
// Shares one data-memory port between two requesters:
//   port 0 = load/store unit (LSU), port 1 = page-table walker (PTW).
// Requests are granted round-robin. Only one transaction is outstanding at a
// time. The granted request is registered onto the memory port, the memory
// response is captured in a single buffer, and that buffer is returned to the
// requester that owns the transaction. A pipeline flush discards an LSU-owned
// response; the memory transaction itself always runs to completion.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   flush_i               pipeline flush, only affects port-0 transactions
//   pX_req_*              request channel of requester X (valid/ready handshake)
//   pX_resp_*             response channel of requester X (valid/ready handshake)
//   mem_req_*             registered request towards memory
//   mem_resp_*            response from memory
//   busy_o                high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module lsu_mem_arbiter #(
  parameter int XLEN             = 64,
  parameter int VIRTUAL_ADDR_LEN = 39
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,

  // Requester 0 (LSU)
  input  logic                        p0_req_valid_i,
  output logic                        p0_req_ready_o,
  input  logic [VIRTUAL_ADDR_LEN-1:0] p0_req_addr_i,
  input  logic [XLEN-1:0]             p0_req_data_i,
  input  logic                        p0_req_we_i,
  input  logic [1:0]                  p0_req_size_i,
  output logic                        p0_resp_valid_o,
  output logic [XLEN-1:0]             p0_resp_data_o,
  input  logic                        p0_resp_ready_i,

  // Requester 1 (page-table walker)
  input  logic                        p1_req_valid_i,
  output logic                        p1_req_ready_o,
  input  logic [VIRTUAL_ADDR_LEN-1:0] p1_req_addr_i,
  input  logic [XLEN-1:0]             p1_req_data_i,
  input  logic                        p1_req_we_i,
  input  logic [1:0]                  p1_req_size_i,
  output logic                        p1_resp_valid_o,
  output logic [XLEN-1:0]             p1_resp_data_o,
  input  logic                        p1_resp_ready_i,

  // Memory port
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [VIRTUAL_ADDR_LEN-1:0] mem_req_addr_o,
  output logic [XLEN-1:0]             mem_req_data_o,
  output logic                        mem_req_we_o,
  output logic [1:0]                  mem_req_size_o,
  input  logic                        mem_resp_valid_i,
  input  logic [XLEN-1:0]             mem_resp_data_i,
  output logic                        mem_resp_ready_o,

  output logic                        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t                      r_state;
  logic                        r_owner;       // port that owns the current transaction
  logic                        r_drop;        // LSU response must be discarded
  logic                        r_last_grant;  // port granted most recently
  logic [VIRTUAL_ADDR_LEN-1:0] r_addr;
  logic [XLEN-1:0]             r_data;
  logic                        r_we;
  logic [1:0]                  r_size;
  logic [XLEN-1:0]             r_resp_buf;
  logic                        r_mem_req_valid;
  logic                        r_mem_resp_ready;
  logic                        r_p0_resp_valid;
  logic                        r_p1_resp_valid;
  logic                        r_busy;

  // ---------------------------------------------------------------------------
  // Combinational arbitration (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic                        w_winner;
  logic                        w_grant;
  logic [VIRTUAL_ADDR_LEN-1:0] w_win_addr;
  logic [XLEN-1:0]             w_win_data;
  logic                        w_win_we;
  logic [1:0]                  w_win_size;
  logic                        w_owner_flush;
  logic                        w_resp_hs;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    w_winner = 1'b0;
    if (p0_req_valid_i && p1_req_valid_i) begin
      // Contention: the port that was not granted last time wins.
      w_winner = ~r_last_grant;
    end else if (p1_req_valid_i) begin
      w_winner = 1'b1;
    end
  end

  assign w_grant        = (r_state == ST_IDLE) && (p0_req_valid_i || p1_req_valid_i);
  assign p0_req_ready_o = w_grant && !w_winner;
  assign p1_req_ready_o = w_grant &&  w_winner;

  assign w_win_addr = w_winner ? p1_req_addr_i : p0_req_addr_i;
  assign w_win_data = w_winner ? p1_req_data_i : p0_req_data_i;
  assign w_win_we   = w_winner ? p1_req_we_i   : p0_req_we_i;
  assign w_win_size = w_winner ? p1_req_size_i : p0_req_size_i;

  // A flush only matters when the LSU owns the transaction.
  assign w_owner_flush = flush_i && !r_owner;

  // Response handshake on the owning port.
  assign w_resp_hs = r_owner ? (r_p1_resp_valid && p1_resp_ready_i)
                             : (r_p0_resp_valid && p0_resp_ready_i);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_owner          <= 1'b0;
      r_drop           <= 1'b0;
      r_last_grant     <= 1'b1;   // makes port 0 the first contention winner
      r_addr           <= '0;
      r_data           <= '0;
      r_we             <= 1'b0;
      r_size           <= 2'd0;
      // NOTE: the response buffer is a plain register, so it can and does get
      // reset; both response data outputs therefore read zero out of reset.
      r_resp_buf       <= '0;
      r_mem_req_valid  <= 1'b0;
      r_mem_resp_ready <= 1'b0;
      r_p0_resp_valid  <= 1'b0;
      r_p1_resp_valid  <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // decision below sees the values from the start of the cycle.
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_addr          <= w_win_addr;
            r_data          <= w_win_data;
            r_we            <= w_win_we;
            r_size          <= w_win_size;
            r_owner         <= w_winner;
            r_last_grant    <= w_winner;
            // A flush in the grant cycle still lets the grant complete, but
            // the LSU response is already marked for discard.
            r_drop          <= flush_i && !w_winner;
            r_mem_req_valid <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= ST_REQ;
          end
        end

        ST_REQ: begin
          // The memory request is never withdrawn; a flush only marks the
          // eventual response for discard.
          if (w_owner_flush) begin
            r_drop <= 1'b1;
          end
          if (mem_req_ready_i) begin
            r_mem_req_valid  <= 1'b0;
            r_mem_resp_ready <= 1'b1;
            r_state          <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (mem_resp_valid_i) begin
            r_resp_buf       <= mem_resp_data_i;
            r_mem_resp_ready <= 1'b0;
            if (r_drop || w_owner_flush) begin
              // Response consumed from memory but never presented.
              r_drop  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_p0_resp_valid <= !r_owner;
              r_p1_resp_valid <=  r_owner;
              r_state         <= ST_DELIVER;
            end
          end else if (w_owner_flush) begin
            r_drop <= 1'b1;
          end
        end

        ST_DELIVER: begin
          // A handshake in the same cycle as a flush counts as delivered;
          // both paths end the transaction identically.
          if (w_resp_hs || w_owner_flush) begin
            r_p0_resp_valid <= 1'b0;
            r_p1_resp_valid <= 1'b0;
            r_drop          <= 1'b0;
            r_busy          <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign mem_req_valid_o  = r_mem_req_valid;
  assign mem_req_addr_o   = r_addr;
  assign mem_req_data_o   = r_data;
  assign mem_req_we_o     = r_we;
  assign mem_req_size_o   = r_size;
  assign mem_resp_ready_o = r_mem_resp_ready;

  assign p0_resp_valid_o  = r_p0_resp_valid;
  assign p1_resp_valid_o  = r_p1_resp_valid;
  // Both requesters see the shared buffer; only the owner's valid is raised.
  assign p0_resp_data_o   = r_resp_buf;
  assign p1_resp_data_o   = r_resp_buf;

  assign busy_o           = r_busy;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for lsu_mem_arbiter.
// Stimulus threads drive directed requests and push the expected memory
// requests and responses into queues; independent monitors pop and compare
// whenever the DUT completes a memory-request or response handshake.
// -----------------------------------------------------------------------------
module tb_lsu_mem_arbiter;

  localparam int XLEN = 64;
  localparam int AW   = 39;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            p0_req_valid_i, p1_req_valid_i;
  logic            p0_req_ready_o, p1_req_ready_o;
  logic [AW-1:0]   p0_req_addr_i,  p1_req_addr_i;
  logic [XLEN-1:0] p0_req_data_i,  p1_req_data_i;
  logic            p0_req_we_i,    p1_req_we_i;
  logic [1:0]      p0_req_size_i,  p1_req_size_i;
  logic            p0_resp_valid_o, p1_resp_valid_o;
  logic [XLEN-1:0] p0_resp_data_o,  p1_resp_data_o;
  logic            p0_resp_ready_i, p1_resp_ready_i;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [AW-1:0]   mem_req_addr_o;
  logic [XLEN-1:0] mem_req_data_o;
  logic            mem_req_we_o;
  logic [1:0]      mem_req_size_o;
  logic            mem_resp_valid_i;
  logic [XLEN-1:0] mem_resp_data_i;
  logic            mem_resp_ready_o;
  logic            busy_o;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.XLEN(XLEN), .VIRTUAL_ADDR_LEN(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .p0_req_valid_i   (p0_req_valid_i),
    .p0_req_ready_o   (p0_req_ready_o),
    .p0_req_addr_i    (p0_req_addr_i),
    .p0_req_data_i    (p0_req_data_i),
    .p0_req_we_i      (p0_req_we_i),
    .p0_req_size_i    (p0_req_size_i),
    .p0_resp_valid_o  (p0_resp_valid_o),
    .p0_resp_data_o   (p0_resp_data_o),
    .p0_resp_ready_i  (p0_resp_ready_i),
    .p1_req_valid_i   (p1_req_valid_i),
    .p1_req_ready_o   (p1_req_ready_o),
    .p1_req_addr_i    (p1_req_addr_i),
    .p1_req_data_i    (p1_req_data_i),
    .p1_req_we_i      (p1_req_we_i),
    .p1_req_size_i    (p1_req_size_i),
    .p1_resp_valid_o  (p1_resp_valid_o),
    .p1_resp_data_o   (p1_resp_data_o),
    .p1_resp_ready_i  (p1_resp_ready_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_data_o   (mem_req_data_o),
    .mem_req_we_o     (mem_req_we_o),
    .mem_req_size_o   (mem_req_size_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .busy_o           (busy_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            we;
    logic [1:0]      size;
  } mem_exp_t;

  typedef struct {
    logic            port;
    logic [XLEN-1:0] data;
  } rsp_exp_t;

  mem_exp_t        exp_mem[$];
  rsp_exp_t        exp_rsp[$];
  logic [XLEN-1:0] mem_rsp[logic [AW-1:0]];  // memory model contents
  logic [AW-1:0]   last_addr = '0;
  int              stall_left = 0;
  int              checks = 0;
  int              failures = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic port, input logic [AW-1:0] a,
                            input logic [XLEN-1:0] d, input logic we,
                            input logic [1:0] sz, input bit has_rsp,
                            input logic [XLEN-1:0] rdata);
    mem_exp_t m;
    rsp_exp_t r;
    m.addr = a; m.data = d; m.we = we; m.size = sz;
    exp_mem.push_back(m);
    if (has_rsp) begin
      r.port = port; r.data = rdata;
      exp_rsp.push_back(r);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: optional request stall, then a 1-cycle response
  // ---------------------------------------------------------------------------
  initial begin
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid_i = 1'b0;
      if (mem_req_valid_o) begin
        if (stall_left > 0) begin
          mem_req_ready_i = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready_i = 1'b1;
        end
      end else begin
        mem_req_ready_i = 1'b0;
      end
      if (mem_resp_ready_o) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = mem_rsp.exists(last_addr) ? mem_rsp[last_addr] : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  task automatic pop_rsp(input logic port, input logic [XLEN-1:0] data);
    rsp_exp_t e;
    if (exp_rsp.size() == 0) begin
      check(port ? "resp_unexpected_p1" : "resp_unexpected_p0", 1, 0);
    end else begin
      e = exp_rsp.pop_front();
      check("resp_port", {63'd0, port}, {63'd0, e.port});
      check("resp_data", data, e.data);
    end
  endtask

  initial begin
    mem_exp_t m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p0_resp_valid_o && p1_resp_valid_o) check("resp_both_valid", 1, 0);
        if (p0_resp_valid_o && p0_resp_ready_i) pop_rsp(1'b0, p0_resp_data_o);
        if (p1_resp_valid_o && p1_resp_ready_i) pop_rsp(1'b1, p1_resp_data_o);
        if (mem_req_valid_o && mem_req_ready_i) begin
          last_addr = mem_req_addr_o;
          if (exp_mem.size() == 0) begin
            check("mem_req_unexpected", 1, 0);
          end else begin
            m = exp_mem.pop_front();
            check("mem_req_addr", {25'd0, mem_req_addr_o}, {25'd0, m.addr});
            check("mem_req_data", mem_req_data_o, m.data);
            check("mem_req_we",   {63'd0, mem_req_we_o}, {63'd0, m.we});
            check("mem_req_size", {62'd0, mem_req_size_o}, {62'd0, m.size});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_req(input logic port, input logic v, input logic [AW-1:0] a,
                           input logic [XLEN-1:0] d, input logic we,
                           input logic [1:0] sz);
    if (port) begin
      p1_req_valid_i = v; p1_req_addr_i = a; p1_req_data_i = d;
      p1_req_we_i = we; p1_req_size_i = sz;
    end else begin
      p0_req_valid_i = v; p0_req_addr_i = a; p0_req_data_i = d;
      p0_req_we_i = we; p0_req_size_i = sz;
    end
  endtask

  // Holds the request until granted; returns just after the edge that ends
  // the grant cycle, with valid still asserted.
  task automatic send(input logic port, input logic [AW-1:0] a,
                      input logic [XLEN-1:0] d, input logic we, input logic [1:0] sz);
    bit got = 1'b0;
    drive_req(port, 1'b1, a, d, we, sz);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = port ? p1_req_ready_o : p0_req_ready_o;
      @(posedge clk); #1;
    end
    if (!got) check(port ? "p1_grant_timeout" : "p0_grant_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    p0_resp_ready_i = 1'b1;
    p1_resp_ready_i = 1'b1;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0, 2'd0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",          {63'd0, busy_o}, 0);
    check("rst_mem_req_valid", {63'd0, mem_req_valid_o}, 0);
    check("rst_mem_resp_rdy",  {63'd0, mem_resp_ready_o}, 0);
    check("rst_p0_resp_valid", {63'd0, p0_resp_valid_o}, 0);
    check("rst_p1_resp_valid", {63'd0, p1_resp_valid_o}, 0);
    check("rst_mem_req_addr",  {25'd0, mem_req_addr_o}, 0);
    check("rst_mem_req_data",  mem_req_data_o, 0);
    check("rst_resp_buf",      p0_resp_data_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Contention right after reset: grants must go p0, p1, p0
    mem_rsp[39'h1100] = 64'h0000_0000_0000_1100;
    mem_rsp[39'h1200] = 64'h0000_0000_0000_1200;
    mem_rsp[39'h1300] = 64'h0000_0000_0000_1300;
    expect_txn(1'b0, 39'h1100, 64'd0, 1'b0, 2'd3, 1'b1, 64'h1100);
    expect_txn(1'b1, 39'h1200, 64'd0, 1'b0, 2'd3, 1'b1, 64'h1200);
    expect_txn(1'b0, 39'h1300, 64'd0, 1'b0, 2'd3, 1'b1, 64'h1300);
    fork
      begin
        send(1'b0, 39'h1100, 64'd0, 1'b0, 2'd3);
        send(1'b0, 39'h1300, 64'd0, 1'b0, 2'd3);
        drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
      end
      begin
        send(1'b1, 39'h1200, 64'd0, 1'b0, 2'd3);
        drive_req(1'b1, 1'b0, '0, '0, 1'b0, 2'd0);
      end
    join
    idle(8);

    // Single LSU load with exact latency
    mem_rsp[39'h1000] = 64'h0000_0000_DEAD_BEEF;
    expect_txn(1'b0, 39'h1000, 64'd0, 1'b0, 2'd3, 1'b1, 64'hDEAD_BEEF);
    send(1'b0, 39'h1000, 64'd0, 1'b0, 2'd3);
    drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    @(negedge clk);  // N+1
    check("t1_mem_valid_n1", {63'd0, mem_req_valid_o}, 1);
    check("t1_mem_addr_n1",  {25'd0, mem_req_addr_o}, 64'h1000);
    @(negedge clk);  // N+2
    check("t1_mem_resp_rdy_n2", {63'd0, mem_resp_ready_o}, 1);
    @(negedge clk);  // N+3
    check("t1_p0_resp_valid_n3", {63'd0, p0_resp_valid_o}, 1);
    check("t1_p1_resp_valid_n3", {63'd0, p1_resp_valid_o}, 0);
    check("t1_shared_buf_p1",    p1_resp_data_o, 64'hDEAD_BEEF);
    idle(4);

    // Backpressure: port-1 store stalled 5 cycles, inputs change meanwhile
    mem_rsp[39'h3300] = 64'h0000_0000_0000_5A5A;
    mem_rsp[39'h3400] = 64'h0000_0000_0000_CAFE;
    expect_txn(1'b1, 39'h3300, 64'h1122_3344_5566_7788, 1'b1, 2'd2, 1'b1, 64'h5A5A);
    expect_txn(1'b0, 39'h3400, 64'd0, 1'b0, 2'd1, 1'b1, 64'hCAFE);
    stall_left = 5;
    send(1'b1, 39'h3300, 64'h1122_3344_5566_7788, 1'b1, 2'd2);
    drive_req(1'b1, 1'b0, 39'h7F_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0);
    fork
      begin
        send(1'b0, 39'h3400, 64'd0, 1'b0, 2'd1);
        drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_mem_valid", {63'd0, mem_req_valid_o}, 1);
          check("bp_mem_addr",  {25'd0, mem_req_addr_o}, 64'h3300);
          check("bp_mem_data",  mem_req_data_o, 64'h1122_3344_5566_7788);
          check("bp_mem_we",    {63'd0, mem_req_we_o}, 1);
          check("bp_mem_size",  {62'd0, mem_req_size_o}, 2);
          check("bp_p0_ready",  {63'd0, p0_req_ready_o}, 0);
        end
      end
    join
    idle(8);

    // Flush in WAIT on port 0: response consumed, never delivered
    expect_txn(1'b0, 39'h2000, 64'd0, 1'b0, 2'd3, 1'b0, 64'd0);
    send(1'b0, 39'h2000, 64'd0, 1'b0, 2'd3);
    drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    for (int i = 0; i < 20 && !mem_resp_ready_o; i++) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    check("fw_resp_consumed", {63'd0, mem_resp_valid_i && mem_resp_ready_o}, 1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("fw_idle_next", {63'd0, busy_o}, 0);
    check("fw_no_p0_resp", {63'd0, p0_resp_valid_o}, 0);
    idle(4);

    // Flush in REQ (stalled) on port 0: drop remembered through WAIT
    stall_left = 2;
    expect_txn(1'b0, 39'h2100, 64'd0, 1'b0, 2'd2, 1'b0, 64'd0);
    send(1'b0, 39'h2100, 64'd0, 1'b0, 2'd2);
    drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    for (int i = 0; i < 20 && busy_o; i++) begin
      @(posedge clk); #1;
    end
    check("fr_returns_idle", {63'd0, busy_o}, 0);
    idle(4);

    // Flush during a port-1 transaction: no effect
    mem_rsp[39'h3000] = 64'h0123_4567_89AB_CDEF;
    expect_txn(1'b1, 39'h3000, 64'd0, 1'b0, 2'd3, 1'b1, 64'h0123_4567_89AB_CDEF);
    send(1'b1, 39'h3000, 64'd0, 1'b0, 2'd3);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0, 2'd0);
    flush_i = 1'b1;
    idle(4);
    flush_i = 1'b0;
    idle(4);
    check("f1_rsp_drained", exp_rsp.size(), 0);

    // Flush in DELIVER on port 0 with no handshake
    mem_rsp[39'h4000] = 64'h0000_0000_0000_AAAA;
    p0_resp_ready_i = 1'b0;
    expect_txn(1'b0, 39'h4000, 64'd0, 1'b0, 2'd3, 1'b0, 64'd0);
    send(1'b0, 39'h4000, 64'd0, 1'b0, 2'd3);
    drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    for (int i = 0; i < 20 && !p0_resp_valid_o; i++) begin
      @(posedge clk); #1;
    end
    check("fd_reached_deliver", {63'd0, p0_resp_valid_o}, 1);
    flush_i = 1'b1;
    @(negedge clk);
    check("fd_valid_same_cycle", {63'd0, p0_resp_valid_o}, 1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("fd_valid_dropped", {63'd0, p0_resp_valid_o}, 0);
    check("fd_idle", {63'd0, busy_o}, 0);
    p0_resp_ready_i = 1'b1;
    idle(4);

    // Reset in DELIVER, then port 0 must win the first contention again
    mem_rsp[39'h5000] = 64'h0000_0000_0000_5555;
    p1_resp_ready_i = 1'b0;
    expect_txn(1'b1, 39'h5000, 64'd0, 1'b0, 2'd3, 1'b0, 64'd0);
    send(1'b1, 39'h5000, 64'd0, 1'b0, 2'd3);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0, 2'd0);
    for (int i = 0; i < 20 && !p1_resp_valid_o; i++) begin
      @(posedge clk); #1;
    end
    check("rd_reached_deliver", {63'd0, p1_resp_valid_o}, 1);
    rst = 1'b1;
    #1;
    check("rd_p1_valid_cleared", {63'd0, p1_resp_valid_o}, 0);
    check("rd_busy_cleared",     {63'd0, busy_o}, 0);
    check("rd_mem_valid_clr",    {63'd0, mem_req_valid_o}, 0);
    check("rd_buf_cleared",      p1_resp_data_o, 0);
    p1_resp_ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    mem_rsp[39'h6000] = 64'h0000_0000_0000_6666;
    mem_rsp[39'h7000] = 64'h0000_0000_0000_7777;
    expect_txn(1'b0, 39'h6000, 64'd0, 1'b0, 2'd3, 1'b1, 64'h6666);
    expect_txn(1'b1, 39'h7000, 64'd0, 1'b0, 2'd3, 1'b1, 64'h7777);
    fork
      begin
        send(1'b0, 39'h6000, 64'd0, 1'b0, 2'd3);
        drive_req(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
      end
      begin
        send(1'b1, 39'h7000, 64'd0, 1'b0, 2'd3);
        drive_req(1'b1, 1'b0, '0, '0, 1'b0, 2'd0);
      end
      begin
        @(negedge clk);
        check("rr_p0_wins_after_rst", {63'd0, p0_req_ready_o}, 1);
        check("rr_p1_loses_after_rst", {63'd0, p1_req_ready_o}, 0);
      end
    join
    idle(10);

    check("end_mem_queue_empty", exp_mem.size(), 0);
    check("end_rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
Shares the single data-memory port between two requesters: port 0 is the LSU and port 1 is the page-table walker. It grants requests round-robin and allows one outstanding transaction at a time. Each request is registered onto the memory port, and the response is buffered and returned to the owning requester. A pipeline flush drops the in-flight response owned by the LSU; the memory transaction itself is never retracted.

Parameters:
XLEN, 64, data width
VIRTUAL_ADDR_LEN, 39, address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush_i  in  1  pipeline flush; kills port-0 response
p0_req_valid_i / p1_req_valid_i  in  1  request valid
p0_req_ready_o / p1_req_ready_o  out  1  request accepted this cycle
p0_req_addr_i / p1_req_addr_i  in  VIRTUAL_ADDR_LEN  address
p0_req_data_i / p1_req_data_i  in  XLEN  store data
p0_req_we_i / p1_req_we_i  in  1  1=store, 0=load
p0_req_size_i / p1_req_size_i  in  2  0=B,1=H,2=W,3=D
p0_resp_valid_o / p1_resp_valid_o  out  1  response valid
p0_resp_data_o / p1_resp_data_o  out  XLEN  response data, shared buffer
p0_resp_ready_i / p1_resp_ready_i  in  1  requester accepts response
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  VIRTUAL_ADDR_LEN  registered address
mem_req_data_o  out  XLEN  registered data
mem_req_we_o  out  1  registered write enable
mem_req_size_o  out  2  registered size
mem_resp_valid_i  in  1  memory response valid
mem_resp_data_i  in  XLEN  memory response data
mem_resp_ready_o  out  1  arbiter accepts response
busy_o  out  1  state != IDLE

Behaviour:
- Reset: FSM goes to IDLE. All *_valid_o, *_ready_o and busy_o are 0. Registered mem_req_* fields are 0, and the response buffer is 0. owner=0, drop=0, last_grant=1, so port 0 wins first. Reset takes effect immediately in any state; any in-flight transaction is abandoned with no response.
- FSM states: IDLE, REQ, WAIT, DELIVER.
- IDLE:
  - Arbitration is combinational.
  - If exactly one port is valid, that port wins.
  - If both are valid, the port != last_grant wins.
  - The winner gets pX_req_ready_o=1 in that cycle. The loser gets 0.
  - On grant: capture addr/data/we/size, set owner and last_grant, go to REQ.
  - drop = flush_i && winner==0. The grant still completes.
- REQ: mem_req_valid_o=1, with fields held stable until mem_req_ready_i. On handshake, go to WAIT.
- WAIT: mem_resp_ready_o=1. On mem_resp_valid_i, capture the data into the buffer.
  - If drop is set, or flush_i is asserted this cycle while owner==0, go directly to IDLE and deliver nothing.
  - Otherwise go to DELIVER.
- DELIVER: resp_valid_o=1 on the owner port only; both resp_data_o outputs carry the buffer.
  - On owner resp_ready_i, go to IDLE.
  - If flush_i is asserted while owner==0, deassert resp_valid next cycle and go to IDLE with no handshake.
  - If the response handshake and flush_i occur in the same cycle, the handshake counts as delivered.
- Flush rules:
  - flush_i in REQ or WAIT with owner==0 sets drop.
  - flush_i never affects port-1 transactions.
  - flush_i never deasserts mem_req_valid_o once it is asserted.
- Stores receive a response as well (the ack data is unspecified); stores are subject to the same drop rules.
- Latency: grant cycle N, then mem_req_valid_o at N+1 at the earliest. With a 1-cycle memory, resp_valid_o arrives at N+3 at the earliest.
- Grants: no new grant is issued until the FSM returns to IDLE, so pX_req_ready_o=0 outside IDLE. Back-to-back transactions need at least one IDLE cycle.
- mem_resp_valid_i outside WAIT is ignored, since mem_resp_ready_o=0 there.

Test Plan:
- Single LSU load: p0 valid with addr=0x1000, size=3, we=0. Response: p0_req_ready at cycle N, mem_req_valid at N+1 with addr 0x1000. mem_resp data 0xDEADBEEF leads to p0_resp_valid and data 0xDEADBEEF, with p1_resp_valid=0 throughout.
- Simultaneous requests after reset: both valid continuously → grants go port 0, port 1, port 0 in that order; each response is routed only to its owner.
- Backpressure: mem_req_ready_i held low 5 cycles, then requester changes its inputs → mem_req_addr_o, mem_req_data_o, mem_req_we_o and mem_req_size_o stay unchanged, and mem_req_valid_o stays 1 for all 5 cycles. The second requester sees req_ready=0 until the FSM returns to IDLE.
- Flush in WAIT on port 0 (addr 0x2000) → the memory response is consumed with mem_resp_ready_o=1, p0_resp_valid never asserts, and the FSM is in IDLE the next cycle.
- Flush during a port-1 transaction → unaffected; p1 receives its data.
- Reset asserted in DELIVER → all valids go to 0 immediately; after release, port 0 wins the first two-way contention.
